bin2seg4: RTL and testbench

- Converts a 14-bit binary value (0..9999) into four 8-bit seven-segment patterns (`dataA`..`dataD`).
- Sits directly upstream of the 4-digit multiplex scanner and drives its `dataA`..`dataD` inputs.
- Conversion is sequential shift-add-3 (double dabble), one bit per clock, with a start/busy/done handshake.
- Outputs hold the last converted value until the next conversion completes. Optional leading-zero blanking; an overflow indication is provided.

---
 rtl/seg7_pkg.sv | 44 ++++
 rtl/seg7_encode.sv | 25 ++
 rtl/bin2seg4.sv | 118 +++++++++++
 tb/tb_bin2seg4.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the binary-to-seven-segment converter: segment patterns,
// FSM state encoding and datapath widths.
package seg7_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int BIN_W      = 14;

    // Segment order is bit0..bit6 = a..g, bit7 = decimal point.
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// One digit of segment encoding: BCD digit with blank/dash overrides, dp bit
// and optional polarity inversion for common-anode displays.
module seg7_encode
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    input  logic       dash_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    logic [7:0] pat;

    always_comb begin
        pat = seg_digit(digit_i);
        if (blank_i) pat = SEG_BLANK;
        if (dash_i)  pat = SEG_DASH;
        pat[7] = dp_i;
        seg_o  = ACTIVE_LOW ? ~pat : pat;
    end

endmodule

// File: rtl/bin2seg4.sv
// Sequential double-dabble converter: 14-bit binary to four seven-segment
// digit patterns, one bit per clock, with start/busy/done handshake.
module bin2seg4
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] value,
    input  logic [3:0]       dp,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [7:0]       dataA,
    output logic [7:0]       dataB,
    output logic [7:0]       dataC,
    output logic [7:0]       dataD
);

    localparam logic [7:0] RST_PAT = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    state_e                           state_q;
    logic [BIN_W-1:0]                 bin_q, bin_d;
    logic [4*BCD_DIGITS-1:0]          bcd_q, bcd_d, bcd_adj;
    logic [3:0]                       cnt_q;
    logic [3:0]                       dp_q;
    logic                             big_q;
    logic                             busy_q, done_q, ovf_q;
    logic [BCD_DIGITS-1:0][7:0]       seg_q, seg_d;
    logic [BCD_DIGITS-1:0]            blank;
    logic                             unused_bcd_msb;

    // Add-3 correction then one left shift of the combined {BCD, binary} register.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_d = {bcd_adj[4*BCD_DIGITS-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
    end

    assign unused_bcd_msb = bcd_adj[4*BCD_DIGITS-1];

    // Digit 3 is thousands; a digit blanks only when all more-significant digits blanked.
    always_comb begin
        blank    = '0;
        blank[3] = BLANK_LZ && (bcd_q[15:12] == 4'd0);
        blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
        blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);
    end

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_enc
        seg7_encode #(.ACTIVE_LOW(ACTIVE_LOW)) u_enc (
            .digit_i (bcd_q[4*g +: 4]),
            .blank_i (blank[g]),
            .dash_i  (big_q),
            .dp_i    (dp_q[g]),
            .seg_o   (seg_d[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            dp_q    <= '0;
            big_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            seg_q   <= {BCD_DIGITS{RST_PAT}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        bin_q   <= value;
                        dp_q    <= dp;
                        big_q   <= (value > 14'd9999);
                        bcd_q   <= '0;
                        cnt_q   <= 4'd13;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    seg_q   <= seg_d;
                    ovf_q   <= big_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign ovf   = ovf_q;
    assign dataA = seg_q[3];
    assign dataB = seg_q[2];
    assign dataC = seg_q[1];
    assign dataD = seg_q[0];

endmodule

// File: tb/tb_bin2seg4.sv
// Randomised and directed bench for bin2seg4; three instances cover the
// default, inverted-polarity and no-blanking configurations side by side.
module tb_bin2seg4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [13:0]      value = '0;
    logic [3:0]       dp = '0;
    logic [2:0]       busy, done, ovf;
    logic [2:0][7:0]  dA, dB, dC, dD;

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] SEGS [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                         8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    always #5 clk = ~clk;

    bin2seg4 #(.ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)) u0 (
        .clk(clk), .rst(rst), .start(start), .value(value), .dp(dp),
        .busy(busy[0]), .done(done[0]), .ovf(ovf[0]),
        .dataA(dA[0]), .dataB(dB[0]), .dataC(dC[0]), .dataD(dD[0]));
    bin2seg4 #(.ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) u1 (
        .clk(clk), .rst(rst), .start(start), .value(value), .dp(dp),
        .busy(busy[1]), .done(done[1]), .ovf(ovf[1]),
        .dataA(dA[1]), .dataB(dB[1]), .dataC(dC[1]), .dataD(dD[1]));
    bin2seg4 #(.ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)) u2 (
        .clk(clk), .rst(rst), .start(start), .value(value), .dp(dp),
        .busy(busy[2]), .done(done[2]), .ovf(ovf[2]),
        .dataA(dA[2]), .dataB(dB[2]), .dataC(dC[2]), .dataD(dD[2]));

    // Reference: decimal digits by division, blanking by scanning from the top.
    function automatic logic [31:0] model(input int v, input logic [3:0] d, input bit al, input bit blz);
        logic [31:0] r;
        logic [7:0]  p;
        int          dig;
        bit          lead;
        r = '0;
        lead = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            dig = (v / (10 ** i)) % 10;
            if (v > 9999) p = 8'h40;
            else if (blz && lead && dig == 0 && i != 0) p = 8'h00;
            else begin
                p = SEGS[dig];
                lead = 1'b0;
            end
            p[7] = d[i];
            if (al) p = ~p;
            r[i*8 +: 8] = p;
        end
        return r;
    endfunction

    function automatic logic [31:0] expect_k(input int k, input int v, input logic [3:0] d);
        return model(v, d, (k == 1), (k != 2));
    endfunction

    function automatic logic [31:0] obs(input int k);
        return {dA[k], dB[k], dC[k], dD[k]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one conversion and wait (bounded) for done; returns cycles to done and busy cycles.
    task automatic convert(input logic [13:0] v, input logic [3:0] d, output int lat, output int bc);
        value = v;
        dp    = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        bc  = (busy[0] === 1'b1) ? 1 : 0;
        while (done[0] !== 1'b1 && lat < 40) begin
            tick();
            lat++;
            if (busy[0] === 1'b1) bc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs(k) !== ((k == 1) ? 32'hFFFF_FFFF : 32'h0)) begin
                bad++;
                $display("FAIL reset_data[%0d]: got %h want %h", k, obs(k), (k == 1) ? 32'hFFFF_FFFF : 32'h0);
            end
        end
        total++;
        if ({busy, done, ovf} !== 9'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0", {busy, done, ovf});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_known();
        int vals [4] = '{1234, 7, 0, 9999};
        int lat, bc;
        for (int t = 0; t < 4; t++) begin
            convert(vals[t][13:0], 4'b0000, lat, bc);
            total++;
            if (lat != 15 || bc != 15) begin
                bad++;
                $display("FAIL known_timing v=%0d: latency %0d busy %0d want 15/15", vals[t], lat, bc);
            end
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs(k) !== expect_k(k, vals[t], 4'b0000)) begin
                    bad++;
                    $display("FAIL known_data v=%0d cfg%0d: got %h want %h", vals[t], k, obs(k), expect_k(k, vals[t], 4'b0000));
                end
            end
            total++;
            if (ovf !== 3'b000) begin
                bad++;
                $display("FAIL known_ovf v=%0d: got %b want 000", vals[t], ovf);
            end
            tick();
            total++;
            if (done !== 3'b000) begin
                bad++;
                $display("FAIL done_pulse v=%0d: got %b want 000", vals[t], done);
            end
        end
    endtask

    task automatic test_overflow();
        int         vals [3] = '{10000, 5, 16383};
        logic [3:0] dps  [3] = '{4'b0100, 4'b0000, 4'b1111};
        int lat, bc;
        for (int t = 0; t < 3; t++) begin
            convert(vals[t][13:0], dps[t], lat, bc);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs(k) !== expect_k(k, vals[t], dps[t])) begin
                    bad++;
                    $display("FAIL ovf_data v=%0d cfg%0d: got %h want %h", vals[t], k, obs(k), expect_k(k, vals[t], dps[t]));
                end
            end
            total++;
            if (ovf !== {3{vals[t] > 9999}}) begin
                bad++;
                $display("FAIL ovf_flag v=%0d: got %b want %b", vals[t], ovf, {3{vals[t] > 9999}});
            end
        end
    endtask

    task automatic test_random();
        int         v, lat, bc;
        logic [3:0] d;
        for (int t = 0; t < 24; t++) begin
            v = (t % 4 == 3) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
            d = 4'($urandom);
            convert(v[13:0], d, lat, bc);
            total++;
            if (lat != 15) begin
                bad++;
                $display("FAIL rand_latency v=%0d: got %0d want 15", v, lat);
            end
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs(k) !== expect_k(k, v, d)) begin
                    bad++;
                    $display("FAIL rand_data v=%0d dp=%b cfg%0d: got %h want %h", v, d, k, obs(k), expect_k(k, v, d));
                end
            end
            total++;
            if (ovf[0] !== (v > 9999)) begin
                bad++;
                $display("FAIL rand_ovf v=%0d: got %b want %b", v, ovf[0], (v > 9999));
            end
            repeat (int'($urandom_range(0, 2))) tick();
        end
    endtask

    task automatic test_ignore_start();
        value = 14'd42;
        dp    = 4'b0000;
        start = 1'b1;
        tick();                       // E0
        start = 1'b0;
        value = 14'd99;
        tick();                       // E1
        tick();                       // E2
        start = 1'b1;
        tick();                       // E3 (busy, must be ignored)
        start = 1'b0;
        repeat (11) tick();           // E4..E14
        start = 1'b1;
        tick();                       // E15 (LOAD, must be ignored)
        start = 1'b0;
        total++;
        if (done[0] !== 1'b1) begin
            bad++;
            $display("FAIL ignore_done: got %b want 1", done[0]);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs(k) !== expect_k(k, 42, 4'b0000)) begin
                bad++;
                $display("FAIL ignore_data cfg%0d: got %h want %h", k, obs(k), expect_k(k, 42, 4'b0000));
            end
        end
        tick();
        total++;
        if (busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL ignore_not_queued: busy got %b want 0", busy[0]);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        convert(14'd321, 4'b0001, lat, bc);
        convert(14'd4567, 4'b1000, lat, bc);  // start lands in the done cycle
        total++;
        if (lat != 15 || bc != 15) begin
            bad++;
            $display("FAIL b2b_timing: latency %0d busy %0d want 15/15", lat, bc);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs(k) !== expect_k(k, 4567, 4'b1000)) begin
                bad++;
                $display("FAIL b2b_data cfg%0d: got %h want %h", k, obs(k), expect_k(k, 4567, 4'b1000));
            end
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        bit seen;
        value = 14'd1234;
        dp    = 4'b0000;
        start = 1'b1;
        tick();                       // E0
        start = 1'b0;
        repeat (7) tick();            // E1..E7
        rst = 1'b1;
        tick();                       // E8
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done !== 3'b000) seen = 1'b1;
            tick();
        end
        total++;
        if (seen || busy !== 3'b000) begin
            bad++;
            $display("FAIL abort_flags: done_seen %0d busy %b want 0/000", seen, busy);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs(k) !== ((k == 1) ? 32'hFFFF_FFFF : 32'h0)) begin
                bad++;
                $display("FAIL abort_blank cfg%0d: got %h want %h", k, obs(k), (k == 1) ? 32'hFFFF_FFFF : 32'h0);
            end
        end
        convert(14'd1234, 4'b0000, lat, bc);
        total++;
        if (lat != 15) begin
            bad++;
            $display("FAIL abort_recover_latency: got %0d want 15", lat);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs(k) !== expect_k(k, 1234, 4'b0000)) begin
                bad++;
                $display("FAIL abort_recover_data cfg%0d: got %h want %h", k, obs(k), expect_k(k, 1234, 4'b0000));
            end
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_overflow();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
